// File: rtl/timer_unit_pkg.sv
// Shared constants, register map and helpers for the four-channel timer unit.
package timer_unit_pkg;

    localparam int          TIMER_NUM       = 4;
    localparam int          TIMER_SEL_W     = 2;
    localparam logic [31:0] TIMER_STRIDE    = 32'h0000_0010;
    localparam logic [31:0] TIMER_BASE_ADDR = 32'h0000_4000;
    localparam logic [31:0] TIMER_END_ADDR  = TIMER_BASE_ADDR + 32'(TIMER_NUM) * TIMER_STRIDE;

    // Register offset within a channel, taken from address bits [3:2].
    typedef enum logic [1:0] {
        REG_CTRL     = 2'd0,
        REG_PRESCALE = 2'd1,
        REG_COUNT    = 2'd2,
        REG_CMP      = 2'd3
    } TimerReg_e;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_AUTO_BIT   = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;
    localparam int CTRL_FLAG_BIT   = 8;

    // Replace the byte lanes of old_val selected by strb with the matching lanes of wdata.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] result;
        result = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/timer_unit_if.sv
// LSU-side request/response bus of the timer unit.
interface timer_unit_if;

    logic        i_lsu_valid;
    logic        i_st_mem;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic [31:0] o_rdata;
    logic        o_rvalid;

    // The LSU issues requests and receives load data.
    modport master (
        output i_lsu_valid, i_st_mem, i_addr, i_wdata, i_wstrb,
        input  o_rdata, o_rvalid
    );

    // The timer unit accepts requests and returns load data.
    modport slave (
        input  i_lsu_valid, i_st_mem, i_addr, i_wdata, i_wstrb,
        output o_rdata, o_rvalid
    );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESCALE/COUNT/CMP registers, prescaler, compare, write port and read mux.
module timer_channel
    import timer_unit_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  TimerReg_e   i_reg,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        irq_en_q, irq_en_d;
    logic        flag_q, flag_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;

    logic        tick;
    logic        match;
    logic [31:0] prescale_wr;

    // Next-state logic: prescaler and compare first, then a store overrides what it touches.
    // NOTE: every variable gets its default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        flag_d     = flag_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        count_d    = count_q;
        cmp_d      = cmp_q;

        tick        = en_q && (pcnt_q == prescale_q);
        match       = tick && (count_q == cmp_q);
        prescale_wr = merge_bytes({16'h0000, prescale_q}, i_wdata, i_wstrb);

        // Prescaler: counts 0..PRESCALE while enabled, parked at 0 otherwise.
        if (!en_q || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

        // Tick: compare, then reload or advance (32-bit wrap is natural).
        if (match) begin
            flag_d  = 1'b1;
            count_d = auto_q ? '0 : count_q + 32'd1;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end

        if (i_we) begin
            case (i_reg)
                REG_CTRL: begin
                    if (i_wstrb[0]) begin
                        en_d     = i_wdata[CTRL_EN_BIT];
                        auto_d   = i_wdata[CTRL_AUTO_BIT];
                        irq_en_d = i_wdata[CTRL_IRQ_EN_BIT];
                        pcnt_d   = '0;
                    end
                    // Write-1-to-clear; a same-cycle compare match keeps the flag set.
                    if (i_wstrb[1] && i_wdata[CTRL_FLAG_BIT] && !match) begin
                        flag_d = 1'b0;
                    end
                end
                REG_PRESCALE: begin
                    prescale_d = prescale_wr[15:0];
                    pcnt_d     = '0;
                end
                // A store to COUNT replaces any tick update in the same cycle.
                REG_COUNT: count_d = merge_bytes(count_q, i_wdata, i_wstrb);
                REG_CMP:   cmp_d   = merge_bytes(cmp_q, i_wdata, i_wstrb);
                default:   ;
            endcase
        end
    end

    // State registers with synchronous reset.
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge; comb logic uses blocking (=).
    always_ff @(posedge i_clk) begin
        // NOTE: these are individual flops, not a memory array, so each one is reset explicitly.
        if (i_rst) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            flag_q     <= 1'b0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            count_q    <= '0;
            cmp_q      <= '0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            flag_q     <= flag_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
        end
    end

    // Read mux for the addressed register; unimplemented bits read as zero.
    always_comb begin
        o_rdata = '0;
        case (i_reg)
            REG_CTRL: begin
                o_rdata[CTRL_EN_BIT]     = en_q;
                o_rdata[CTRL_AUTO_BIT]   = auto_q;
                o_rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
                o_rdata[CTRL_FLAG_BIT]   = flag_q;
            end
            REG_PRESCALE: o_rdata = {16'h0000, prescale_q};
            REG_COUNT:    o_rdata = count_q;
            REG_CMP:      o_rdata = cmp_q;
            default:      o_rdata = '0;
        endcase
    end

    assign o_irq = flag_q & irq_en_q;

endmodule

// File: rtl/timer_unit.sv
// Timer unit top: address decode, per-channel instances and the one-cycle load response register.
module timer_unit
    import timer_unit_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    timer_unit_if.slave          bus,
    output logic [TIMER_NUM-1:0] o_irq
);

    logic                   hit;
    logic [TIMER_SEL_W-1:0] ch_sel;
    TimerReg_e              reg_sel;
    logic [31:0]            ch_rdata [TIMER_NUM];

    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;

    assign hit     = bus.i_lsu_valid
                     && (bus.i_addr >= TIMER_BASE_ADDR)
                     && (bus.i_addr <  TIMER_END_ADDR);
    assign ch_sel  = bus.i_addr[5:4];
    assign reg_sel = TimerReg_e'(bus.i_addr[3:2]);

    for (genvar n = 0; n < TIMER_NUM; n++) begin : g_ch
        timer_channel u_channel (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_we    (hit && bus.i_st_mem && (ch_sel == TIMER_SEL_W'(n))),
            .i_reg   (reg_sel),
            .i_wdata (bus.i_wdata),
            .i_wstrb (bus.i_wstrb),
            .o_rdata (ch_rdata[n]),
            .o_irq   (o_irq[n])
        );
    end

    // Capture the addressed register on a load hit; zero data when no load was accepted.
    always_comb begin
        rvalid_d = hit && !bus.i_st_mem;
        rdata_d  = rvalid_d ? ch_rdata[ch_sel] : '0;
    end

    // Response register; reset suppresses a load accepted in the reset cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.o_rvalid = rvalid_q;
    assign bus.o_rdata  = rdata_q;

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: directed scenarios plus random traffic against a behavioural model.
module tb_timer_unit;
    import timer_unit_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [3:0] o_irq;

    timer_unit_if bus ();

    timer_unit dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus),
        .o_irq (o_irq)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard: expected load data tagged with the cycle it must appear in.
    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Monitor: sampled mid-cycle, away from the rising edge.
    always @(negedge i_clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            check("rvalid", {31'b0, bus.o_rvalid}, 32'd1);
            check("rdata", bus.o_rdata, mon_e.data);
        end else if (bus.o_rvalid) begin
            check("spurious_rvalid", {31'b0, bus.o_rvalid}, 32'd0);
        end else begin
            check("idle_rdata", bus.o_rdata, 32'd0);
        end
    end

    // ---------------- behavioural model ----------------
    bit          m_en[4], m_auto[4], m_irqen[4], m_flag[4];
    logic [15:0] m_pre[4], m_pcnt[4];
    logic [31:0] m_count[4], m_cmp[4];

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int c, input int rg);
        case (rg)
            0:       return {23'b0, m_flag[c], 5'b0, m_irqen[c], m_auto[c], m_en[c]};
            1:       return {16'b0, m_pre[c]};
            2:       return m_count[c];
            default: return m_cmp[c];
        endcase
    endfunction

    function automatic logic [3:0] m_irq();
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = m_flag[c] & m_irqen[c];
        return r;
    endfunction

    task automatic model_cycle(input bit rst, input bit v, input bit st, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] ws,
                               input bit use_exp, input logic [31:0] exp_val);
        bit hit;
        int ch, rg;
        exp_t e;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_en[c] = 0; m_auto[c] = 0; m_irqen[c] = 0; m_flag[c] = 0;
                m_pre[c] = 0; m_pcnt[c] = 0; m_count[c] = 0; m_cmp[c] = 0;
            end
            return;
        end
        hit = v && (a >= 32'h4000) && (a < 32'h4040);
        ch  = hit ? int'((a - 32'h4000) / 16) : 0;
        rg  = hit ? int'(((a - 32'h4000) % 16) / 4) : 0;
        if (hit && !st) begin
            e.cyc  = cyc + 1;
            e.data = use_exp ? exp_val : m_read(ch, rg);
            exp_q.push_back(e);
        end
        for (int c = 0; c < 4; c++) begin
            bit          tick, matched;
            logic [31:0] nc, tmp;
            logic [15:0] np;
            tick    = m_en[c] && (m_pcnt[c] == m_pre[c]);
            matched = tick && (m_count[c] == m_cmp[c]);
            np      = (m_en[c] && !tick) ? m_pcnt[c] + 16'd1 : 16'd0;
            nc      = !tick ? m_count[c] : ((matched && m_auto[c]) ? 32'd0 : m_count[c] + 32'd1);
            if (hit && st && ch == c) begin
                case (rg)
                    0: begin
                        if (ws[0]) begin
                            m_en[c] = wd[0]; m_auto[c] = wd[1]; m_irqen[c] = wd[2]; np = 0;
                        end
                        if (ws[1] && wd[8]) m_flag[c] = 0;
                    end
                    1: begin
                        tmp = lanes({16'b0, m_pre[c]}, wd, ws);
                        m_pre[c] = tmp[15:0];
                        np = 0;
                    end
                    2: nc = lanes(m_count[c], wd, ws);
                    default: m_cmp[c] = lanes(m_cmp[c], wd, ws);
                endcase
            end
            if (matched) m_flag[c] = 1;
            m_count[c] = nc;
            m_pcnt[c]  = np;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit v, input bit st, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input bit use_exp = 0, input logic [31:0] exp_val = 0);
        i_rst           = rst;
        bus.i_lsu_valid = v;
        bus.i_st_mem    = st;
        bus.i_addr      = a;
        bus.i_wdata     = wd;
        bus.i_wstrb     = ws;
        model_cycle(rst, v, st, a, wd, ws, use_exp, exp_val);
        @(posedge i_clk);
        #1;
        check("irq", {28'b0, o_irq}, {28'b0, m_irq()});
    endtask

    task automatic idle();                                          step(0, 0, 0, 32'h0, 32'h0, 4'h0);            endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s); step(0, 1, 1, a, d, s);  endtask
    task automatic rd(input logic [31:0] a);                        step(0, 1, 0, a, 32'h0, 4'h0);                endtask
    task automatic rd_exp(input logic [31:0] a, input logic [31:0] x); step(0, 1, 0, a, 32'h0, 4'h0, 1, x);     endtask

    task automatic random_phase(input int n);
        bit          r, v, st;
        logic [31:0] a, wd;
        logic [3:0]  ws;
        for (int i = 0; i < n; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 9) < 7);
            st = $urandom_range(0, 1);
            a  = 32'h3FF0 + $urandom_range(0, 32'h5F);
            ws = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case (a[3:2])
                2'd0:    wd = $urandom;
                2'd1:    wd = $urandom_range(0, 3);
                2'd2:    wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 12);
                default: wd = $urandom_range(0, 12);
            endcase
            step(r, v, st, a, wd, ws);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        bus.i_lsu_valid = 1'b0; bus.i_st_mem = 1'b0;
        bus.i_addr = '0; bus.i_wdata = '0; bus.i_wstrb = '0;

        // Reset state.
        step(1, 0, 0, 32'h0, 32'h0, 4'h0);
        step(1, 0, 0, 32'h0, 32'h0, 4'h0);
        check("irq_after_reset", {28'b0, o_irq}, 32'd0);
        for (int k = 0; k < 16; k++) rd_exp(32'h4000 + 32'(k * 4), 32'h0);

        // Auto-reload with interrupt on channel 0, then the set/clear race.
        wr(32'h4004, 32'h0, 4'hF);
        wr(32'h400C, 32'h2, 4'hF);
        wr(32'h4000, 32'h7, 4'h1);
        rd_exp(32'h4008, 32'h0);
        rd_exp(32'h4008, 32'h1);
        rd_exp(32'h4008, 32'h2);
        check("irq0_after_match", {31'b0, o_irq[0]}, 32'd1);
        rd_exp(32'h4008, 32'h0);
        wr(32'h4000, 32'h100, 4'b0010);
        check("irq0_after_w1c", {31'b0, o_irq[0]}, 32'd0);
        wr(32'h4000, 32'h100, 4'b0010);
        check("irq0_set_wins", {31'b0, o_irq[0]}, 32'd1);
        rd_exp(32'h4000, 32'h107);
        wr(32'h4000, 32'h100, 4'b0011);
        check("irq0_disabled", {31'b0, o_irq[0]}, 32'd0);

        // Prescale timing on channel 1.
        wr(32'h4014, 32'h3, 4'hF);
        wr(32'h401C, 32'hFFFF_FFFF, 4'hF);
        wr(32'h4018, 32'h0, 4'hF);
        wr(32'h4010, 32'h1, 4'h1);
        repeat (19) idle();
        rd(32'h4018);
        rd_exp(32'h4018, 32'h5);
        wr(32'h4010, 32'h0, 4'h1);

        // Wrap and store/tick collision on channel 3.
        wr(32'h4034, 32'h0, 4'hF);
        wr(32'h403C, 32'h5, 4'hF);
        wr(32'h4038, 32'hFFFF_FFFF, 4'hF);
        wr(32'h4030, 32'h1, 4'h1);
        idle();
        rd_exp(32'h4038, 32'h0);
        wr(32'h4038, 32'h55, 4'hF);
        rd_exp(32'h4038, 32'h55);
        wr(32'h4030, 32'h0, 4'h1);

        // Byte lanes, load latency and out-of-range requests.
        wr(32'h4028, 32'hAABB_CCDD, 4'b0101);
        rd_exp(32'h4028, 32'h00BB_00DD);
        rd(32'h4040);
        wr(32'h4040, 32'hFFFF_FFFF, 4'hF);
        wr(32'h3FFC, 32'hFFFF_FFFF, 4'hF);
        rd(32'h402B);
        rd_exp(32'h4034, 32'h0);

        // Reset in the middle of counting, with a load in the reset cycle.
        wr(32'h4020, 32'h0, 4'hF);
        wr(32'h402C, 32'h1234, 4'hF);
        wr(32'h4028, 32'h1234, 4'hF);
        wr(32'h4020, 32'h5, 4'h1);
        idle();
        step(1, 1, 0, 32'h4028, 32'h0, 4'h0);
        check("irq_after_mid_reset", {28'b0, o_irq}, 32'd0);
        for (int k = 0; k < 16; k++) rd_exp(32'h4000 + 32'(k * 4), 32'h0);

        // Random traffic against the model, then a full register sweep.
        random_phase(600);
        for (int k = 0; k < 16; k++) rd(32'h4000 + 32'(k * 4));
        repeat (3) idle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
